// File: rtl/ticket_inventory_engine_if.sv
// Request/response bus of the ticket inventory engine. master issues requests,
// slave (the engine) accepts them and returns a one-cycle response strobe.
interface ticket_inventory_engine_if #(
  parameter int CLASS_W = 2,
  parameter int DATE_W  = 5,
  parameter int QTY_W   = 3,
  parameter int SEAT_W  = 6,
  parameter int PRICE_W = 12
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the slave raises req_ready only when idle, and resp_valid pulses once per transfer.
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [CLASS_W-1:0] req_class;
  logic [DATE_W-1:0]  req_date;
  logic [QTY_W-1:0]   req_qty;
  logic               resp_valid;
  logic [2:0]         resp_status;
  logic [PRICE_W-1:0] resp_price;
  logic [SEAT_W-1:0]  resp_seats_left;

  modport master (
    output req_valid, req_op, req_class, req_date, req_qty,
    input  req_ready, resp_valid, resp_status, resp_price, resp_seats_left
  );

  modport slave (
    input  req_valid, req_op, req_class, req_date, req_qty,
    output req_ready, resp_valid, resp_status, resp_price, resp_seats_left
  );
endinterface

// File: rtl/ticket_inventory_engine.sv
// Seat inventory engine: one booked-seat counter per (class, date), serving
// check/book/cancel requests through a four-state IDLE/LOOKUP/UPDATE/RESP FSM.
module ticket_inventory_engine #(
  parameter int NUM_CLASSES = 3,
  parameter int NUM_DATES   = 31,
  parameter int CAPACITY    = 40,
  parameter int MAX_QTY     = 4,
  parameter int PRICE_BASE  = 100,
  parameter int PRICE_STEP  = 50,
  parameter int CLASS_W     = 2,
  parameter int DATE_W      = 5,
  parameter int QTY_W       = 3,
  parameter int SEAT_W      = 6,
  parameter int PRICE_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  ticket_inventory_engine_if.slave bus,
  output logic [1:0]              dbg_state_o
);

  localparam int NUM_ENTRIES = NUM_CLASSES * NUM_DATES;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);

  localparam logic [1:0] OP_BOOK   = 2'b01;
  localparam logic [1:0] OP_CANCEL = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_SOLD_OUT = 3'd1;
  localparam logic [2:0] ST_NOTHING  = 3'd2;
  localparam logic [2:0] ST_BAD_ARG  = 3'd3;
  localparam logic [2:0] ST_BAD_OP   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q;
  logic [CLASS_W-1:0] cls_q;
  logic [DATE_W-1:0]  date_q;
  logic [QTY_W-1:0]   qty_q;
  logic               bad_arg_q, bad_op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SEAT_W-1:0]  booked_rd_q;
  logic [SEAT_W-1:0]  booked_q [NUM_ENTRIES];
  logic [2:0]         status_q;
  logic [PRICE_W-1:0] price_q;
  logic [SEAT_W-1:0]  seats_q;

  logic               args_ok;
  logic [IDX_W-1:0]   idx_d;
  logic [SEAT_W-1:0]  free_seats, qty_s;
  logic [PRICE_W-1:0] unit_price, amount;
  logic               upd_we;
  logic [SEAT_W-1:0]  upd_val, upd_seats;
  logic [2:0]         upd_status;
  logic [PRICE_W-1:0] upd_price;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Out-of-range arguments never form an index, so the counter read stays in bounds.
  always_comb begin
    args_ok = (int'(cls_q) < NUM_CLASSES) && (int'(date_q) < NUM_DATES) &&
              (qty_q != '0) && (int'(qty_q) <= MAX_QTY);
    idx_d   = args_ok ? (IDX_W'(cls_q) * IDX_W'(NUM_DATES) + IDX_W'(date_q)) : '0;
  end

  always_comb begin
    free_seats = SEAT_W'(CAPACITY) - booked_rd_q;
    qty_s      = SEAT_W'(qty_q);
    unit_price = PRICE_W'(PRICE_BASE) + PRICE_W'(cls_q) * PRICE_W'(PRICE_STEP);
    amount     = unit_price * PRICE_W'(qty_q);
    upd_we     = 1'b0;
    upd_val    = booked_rd_q;
    upd_status = ST_OK;
    upd_price  = '0;
    upd_seats  = free_seats;
    if (bad_arg_q) begin
      upd_status = ST_BAD_ARG;
      upd_seats  = '0;
    end else if (bad_op_q) begin
      upd_status = ST_BAD_OP;
      upd_seats  = '0;
    end else begin
      case (op_q)
        OP_BOOK: begin
          if (free_seats >= qty_s) begin
            upd_we    = 1'b1;
            upd_val   = booked_rd_q + qty_s;
            upd_price = amount;
            upd_seats = free_seats - qty_s;
          end else begin
            upd_status = ST_SOLD_OUT;
          end
        end
        OP_CANCEL: begin
          if (booked_rd_q >= qty_s) begin
            upd_we    = 1'b1;
            upd_val   = booked_rd_q - qty_s;
            upd_price = amount;
            upd_seats = free_seats + qty_s;
          end else begin
            upd_status = ST_NOTHING;
          end
        end
        default: begin
          upd_price  = amount;
          upd_status = (free_seats >= qty_s) ? ST_OK : ST_SOLD_OUT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      cls_q       <= '0;
      date_q      <= '0;
      qty_q       <= '0;
      bad_arg_q   <= 1'b0;
      bad_op_q    <= 1'b0;
      idx_q       <= '0;
      booked_rd_q <= '0;
      status_q    <= '0;
      price_q     <= '0;
      seats_q     <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) booked_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          op_q   <= bus.req_op;
          cls_q  <= bus.req_class;
          date_q <= bus.req_date;
          qty_q  <= bus.req_qty;
        end
        S_LOOKUP: begin
          bad_arg_q   <= !args_ok;
          bad_op_q    <= (op_q == OP_RSVD);
          idx_q       <= idx_d;
          booked_rd_q <= args_ok ? booked_q[idx_d] : '0;
        end
        S_UPDATE: begin
          if (upd_we) booked_q[idx_q] <= upd_val;
          status_q <= upd_status;
          price_q  <= upd_price;
          seats_q  <= upd_seats;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = (state_q == S_IDLE);
  assign bus.resp_valid      = (state_q == S_RESP);
  assign bus.resp_status     = status_q;
  assign bus.resp_price      = price_q;
  assign bus.resp_seats_left = seats_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_ticket_inventory_engine.sv
// Directed bench for ticket_inventory_engine: a seat-count model predicts each
// response, and a negedge compare process checks every response strobe against it.
module tb_ticket_inventory_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [20:0] exp_q[$];
  int          booked_m [3][31];
  bit          prev_valid = 1'b0;

  ticket_inventory_engine_if #(.CLASS_W(2), .DATE_W(5), .QTY_W(3), .SEAT_W(6), .PRICE_W(12)) bus ();

  ticket_inventory_engine dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int d = 0; d < 31; d++) booked_m[c][d] = 0;
  endtask

  // Spec rules as plain arithmetic: returns {status, price, seats_left}.
  task automatic model_op(input int op, input int cls, input int date, input int qty,
                          output logic [20:0] e);
    int amount, free_s, st, pr, sl;
    amount = (100 + cls * 50) * qty;
    if (cls >= 3 || date >= 31 || qty == 0 || qty > 4) begin
      st = 3; pr = 0; sl = 0;
    end else if (op == 3) begin
      st = 4; pr = 0; sl = 0;
    end else begin
      free_s = 40 - booked_m[cls][date];
      if (op == 1) begin
        if (free_s >= qty) begin
          booked_m[cls][date] += qty; st = 0; pr = amount; sl = free_s - qty;
        end else begin
          st = 1; pr = 0; sl = free_s;
        end
      end else if (op == 2) begin
        if (booked_m[cls][date] >= qty) begin
          booked_m[cls][date] -= qty; st = 0; pr = amount; sl = free_s + qty;
        end else begin
          st = 2; pr = 0; sl = free_s;
        end
      end else begin
        st = (free_s >= qty) ? 0 : 1; pr = amount; sl = free_s;
      end
    end
    e = {3'(st), 12'(pr), 6'(sl)};
  endtask

  task automatic drive_req(input int op, input int cls, input int date, input int qty);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    bus.req_class = 2'(cls);
    bus.req_date  = 5'(date);
    bus.req_qty   = 3'(qty);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_ready_before_issue", int'(bus.req_ready), 1);
  endtask

  // Issues one request; l_* are hand-computed values that pin the model.
  task automatic issue(input int op, input int cls, input int date, input int qty,
                       input int l_st, input int l_pr, input int l_sl);
    logic [20:0] e;
    int n;
    wait_ready();
    drive_req(op, cls, date, qty);
    model_op(op, cls, date, qty, e);
    check_val("model_status", int'(e[20:18]), l_st);
    check_val("model_price",  int'(e[17:6]),  l_pr);
    check_val("model_seats",  int'(e[5:0]),   l_sl);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = ~bus.req_op;
    bus.req_class = ~bus.req_class;
    bus.req_date  = ~bus.req_date;
    bus.req_qty   = ~bus.req_qty;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 8);
    check_val("resp_latency", n, 3);
  endtask

  always @(negedge clk) begin
    logic [20:0] e;
    if (bus.resp_valid) begin
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL resp_valid_width: got high on 2 consecutive cycles expected 1");
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        check_val("resp_status", int'(bus.resp_status),     int'(e[20:18]));
        check_val("resp_price",  int'(bus.resp_price),      int'(e[17:6]));
        check_val("resp_seats",  int'(bus.resp_seats_left), int'(e[5:0]));
      end
    end
    prev_valid = bus.resp_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_class = '0;
    bus.req_date  = '0;
    bus.req_qty   = '0;
    model_reset();

    // reset state, with a request offered during reset that must be ignored
    repeat (2) @(negedge clk);
    drive_req(1, 0, 0, 1);
    @(negedge clk);
    check_val("rst_req_ready",  int'(bus.req_ready), 1);
    check_val("rst_resp_valid", int'(bus.resp_valid), 0);
    check_val("rst_status",     int'(bus.resp_status), 0);
    check_val("rst_price",      int'(bus.resp_price), 0);
    check_val("rst_seats",      int'(bus.resp_seats_left), 0);
    check_val("rst_state",      int'(dbg_state), 0);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // book / cancel basics
    issue(1, 0, 5, 1, 0, 100, 39);
    issue(2, 0, 5, 1, 0, 100, 40);
    issue(2, 0, 5, 1, 2, 0, 40);

    // fill class 1 date 10 to capacity
    for (int k = 1; k <= 10; k++) issue(1, 1, 10, 4, 0, 600, 40 - 4 * k);
    issue(1, 1, 10, 4, 1, 0, 0);
    issue(0, 1, 10, 1, 1, 150, 0);

    // dates independent
    issue(1, 2, 15, 2, 0, 400, 38);
    issue(0, 2, 14, 1, 0, 200, 40);

    // argument / opcode errors, BAD_ARG over BAD_OP
    issue(1, 3, 5, 1, 3, 0, 0);
    issue(1, 0, 31, 1, 3, 0, 0);
    issue(1, 0, 5, 0, 3, 0, 0);
    issue(1, 0, 5, 5, 3, 0, 0);
    issue(3, 0, 5, 1, 4, 0, 0);
    issue(3, 3, 5, 1, 3, 0, 0);

    // counters untouched by the errors
    issue(0, 2, 15, 1, 0, 200, 38);
    issue(0, 0, 5, 1, 0, 100, 40);
    issue(0, 1, 10, 4, 1, 600, 0);

    // partial cancel refused, full cancel accepted
    issue(2, 2, 15, 4, 2, 0, 38);
    issue(2, 2, 15, 2, 0, 400, 40);

    // reset while a book on class 0 date 0 is in UPDATE
    wait_ready();
    drive_req(1, 0, 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_state_update", int'(dbg_state), 2);
    rst = 1'b1;
    #1;
    check_val("mid_rst_req_ready",  int'(bus.req_ready), 1);
    check_val("mid_rst_resp_valid", int'(bus.resp_valid), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_val("post_rst_no_resp", int'(bus.resp_valid), 0);
    end
    check_val("post_rst_req_ready", int'(bus.req_ready), 1);
    issue(0, 0, 0, 1, 0, 100, 40);
    issue(0, 1, 10, 1, 0, 150, 40);

    repeat (3) @(negedge clk);
    check_val("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
